serial_adder_seq: RTL and testbench

SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder_seq.sv | 115 +++++++++++
 tb/tb_serial_adder_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single 1-bit full adder, time-shared by serial_adder_seq.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per cycle, LSB first.
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic             load;

    fa_cell u_fa (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // A new operation may be accepted from IDLE or straight out of DONE.
    assign load = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (load) begin
            a_d   = a;
            b_d   = b;
            c_d   = cin;
            cnt_d = '0;
            res_d = '0;
        end else if (state_q == RUN) begin
            // New sum bit enters at the MSB; after WIDTH shifts bit 0 is at the LSB.
            res_d = WIDTH'({fa_s, res_q} >> 1);
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = fa_co;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                sum_d  = res_d;
                cout_d = fa_co;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed self-checking bench for serial_adder_seq at WIDTH=8.
module tb_serial_adder_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i, b_i;
    logic         cin_i;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks   = 0;
    int failures = 0;

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .cin   (cin_i),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Drives one operation and waits (bounded) for done. Operands are scrambled
    // after acceptance; pulse_at>0 raises start for one cycle mid-run.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input int pulse_at, output int nbusy, output int dat,
                         output logic [W-1:0] s, output logic co, output bit bad);
        logic [W-1:0] prev;
        @(negedge clk);
        start = 1'b1; a_i = av; b_i = bv; cin_i = cv;
        prev  = sum;
        nbusy = 0; dat = 0; bad = 1'b0; s = 'x; co = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == pulse_at) begin
                start = 1'b1; a_i = 8'hFF; b_i = 8'hFF; cin_i = 1'b1;
            end else begin
                start = 1'b0; a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
            end
            if (busy) nbusy++;
            if (busy && done) bad = 1'b1;
            if (!done && (sum !== prev)) bad = 1'b1;
            if (done) begin
                dat = i; s = sum; co = cout;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int dat;
        start = 1'b1; a_i = 8'h01; b_i = 8'h02; cin_i = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_holds_idle: got busy=%b, want 0", busy);
        end
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL first_edge_accept: got busy=%b, want 1", busy);
        end
        dat = 0;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin dat = i; break; end
        end
        checks++;
        if (dat != 9 || sum !== 8'h03 || cout !== 1'b0) begin
            failures++;
            $display("FAIL first_op: got done_at=%0d sum=%h cout=%b, want 9 03 0", dat, sum, cout);
        end
    endtask

    task automatic test_basic();
        int nb, dat; logic [W-1:0] s; logic co; bit bad;
        do_op(8'h5A, 8'h3C, 1'b0, 0, nb, dat, s, co, bad);
        checks++;
        if (nb != 8 || dat != 9) begin
            failures++;
            $display("FAIL basic_timing: got busy_cycles=%0d done_at=%0d, want 8 9", nb, dat);
        end
        checks++;
        if (s !== 8'h96 || co !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got sum=%h cout=%b, want 96 0", s, co);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL basic_protocol: got overlap_or_early_sum=1, want 0");
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h96) begin
            failures++;
            $display("FAIL basic_after_done: got done=%b busy=%b sum=%h, want 0 0 96", done, busy, sum);
        end
    endtask

    task automatic test_carry();
        int nb, dat; logic [W-1:0] s; logic co; bit bad;
        do_op(8'hFF, 8'h01, 1'b0, 0, nb, dat, s, co, bad);
        checks++;
        if (s !== 8'h00 || co !== 1'b1 || dat != 9) begin
            failures++;
            $display("FAIL carry_ff_01: got sum=%h cout=%b done_at=%0d, want 00 1 9", s, co, dat);
        end
        do_op(8'hFF, 8'h00, 1'b1, 0, nb, dat, s, co, bad);
        checks++;
        if (s !== 8'h00 || co !== 1'b1 || dat != 9) begin
            failures++;
            $display("FAIL carry_ff_cin: got sum=%h cout=%b done_at=%0d, want 00 1 9", s, co, dat);
        end
        do_op(8'hC8, 8'h64, 1'b1, 0, nb, dat, s, co, bad);
        checks++;
        if (s !== 8'h2D || co !== 1'b1) begin
            failures++;
            $display("FAIL carry_c8_64: got sum=%h cout=%b, want 2d 1", s, co);
        end
    endtask

    task automatic test_ignore_start();
        int nb, dat; logic [W-1:0] s; logic co; bit bad;
        do_op(8'h0F, 8'h01, 1'b0, 3, nb, dat, s, co, bad);
        checks++;
        if (s !== 8'h10 || co !== 1'b0 || dat != 9 || nb != 8) begin
            failures++;
            $display("FAIL ignore_start: got sum=%h cout=%b done_at=%0d busy=%0d, want 10 0 9 8", s, co, dat, nb);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone; int nb, dat; logic [W-1:0] s; logic co; bit bad;
        @(negedge clk);
        start = 1'b1; a_i = 8'h5A; b_i = 8'h3C; cin_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== '0) begin
            failures++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL reset_no_done: got active_cycles=%0d, want 0", ndone);
        end
        do_op(8'h12, 8'h34, 1'b1, 0, nb, dat, s, co, bad);
        checks++;
        if (s !== 8'h47 || co !== 1'b0 || dat != 9) begin
            failures++;
            $display("FAIL reset_recover: got sum=%h cout=%b done_at=%0d, want 47 0 9", s, co, dat);
        end
    endtask

    task automatic test_back_to_back();
        int d2;
        @(negedge clk);
        start = 1'b1; a_i = 8'h11; b_i = 8'h22; cin_i = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 8; i++) @(negedge clk);
        // Raised in the last RUN cycle and held through DONE.
        start = 1'b1; a_i = 8'h80; b_i = 8'h80; cin_i = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || sum !== 8'h33 || cout !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got done=%b sum=%h cout=%b, want 1 33 0", done, sum, cout);
        end
        @(negedge clk);
        start = 1'b0; a_i = 8'h00; b_i = 8'h00;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_idle: got busy=%b done=%b, want 1 0", busy, done);
        end
        d2 = 0;
        for (int i = 11; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin d2 = i; break; end
        end
        checks++;
        if (d2 != 18 || sum !== 8'h00 || cout !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got done_at=%0d sum=%h cout=%b, want 18 00 1", d2, sum, cout);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
